// File: rtl/calc_disp_pkg.sv
// Shared types and constants for the calculator seven-segment display driver.
// Leading-zero blanking is enabled in the top when CALC_DISP_LZ_BLANK_EN is defined.
package calc_disp_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_SHIFT = 2'd1,
      ST_DONE  = 2'd2
   } state_e;

   // Active-low segment patterns, bit order {g,f,e,d,c,b,a}
   localparam logic [6:0] SEG_BLANK = 7'b1111111;
   localparam logic [6:0] SEG_DASH  = 7'b0111111;

   localparam logic [6:0] SEG_DIGITS [0:9] = '{
      7'b1000000,  // 0
      7'b1111001,  // 1
      7'b0100100,  // 2
      7'b0110000,  // 3
      7'b0011001,  // 4
      7'b0010010,  // 5
      7'b0000010,  // 6
      7'b1111000,  // 7
      7'b0000000,  // 8
      7'b0010000   // 9
   };

   // Largest value representable in ndig decimal digits (10^ndig - 1)
   function automatic logic [63:0] max_val(input int unsigned ndig);
      logic [63:0] v;
      v = 64'd1;
      for (int unsigned i = 0; i < ndig; i++) begin
         v = v * 64'd10;
      end
      return v - 64'd1;
   endfunction

endpackage

// File: rtl/calc_display_driver_bcd_to_7seg.sv
// Combinational BCD nibble to active-low seven-segment pattern; 10-15 show blank.
module bcd_to_7seg
   import calc_disp_pkg::*;
(
   input  logic [3:0] bcd,
   output logic [6:0] seg
);

   // Digit table lookup with blank for non-decimal codes
   always_comb begin
      seg = SEG_BLANK;
      case (bcd)
         4'd0: seg = SEG_DIGITS[0];
         4'd1: seg = SEG_DIGITS[1];
         4'd2: seg = SEG_DIGITS[2];
         4'd3: seg = SEG_DIGITS[3];
         4'd4: seg = SEG_DIGITS[4];
         4'd5: seg = SEG_DIGITS[5];
         4'd6: seg = SEG_DIGITS[6];
         4'd7: seg = SEG_DIGITS[7];
         4'd8: seg = SEG_DIGITS[8];
         4'd9: seg = SEG_DIGITS[9];
         default: seg = SEG_BLANK;
      endcase
   end

endmodule

// File: rtl/calc_display_driver.sv
// Serial double-dabble binary-to-seven-segment driver for the calculator displays.
// Define CALC_DISP_LZ_BLANK_EN to blank displays above the most-significant nonzero digit.
module calc_display_driver
   import calc_disp_pkg::*;
#(
   parameter int unsigned NDIG = 8,
   parameter int unsigned W    = 27
)
(
   input  logic             clock,
   input  logic             reset,
   input  logic [W-1:0]     digits,
   output logic [6:0]       displays [NDIG-1:0],
   output logic             busy,
   output logic             valid
);

   localparam int unsigned BW = 4 * NDIG;
   localparam int unsigned CW = (W > 1) ? $clog2(W) : 1;
   localparam logic [63:0] MAX_VAL = max_val(NDIG);

   state_e          state_q, state_d;
   logic [W-1:0]    snap_q, snap_d;
   logic [W-1:0]    bin_q, bin_d;
   logic [BW-1:0]   bcd_q, bcd_d;
   logic [CW-1:0]   cnt_q, cnt_d;
   logic            ovf_q, ovf_d;
   logic            force_q, force_d;
   logic            busy_q, busy_d;
   logic            valid_q, valid_d;
   logic [6:0]      displays_q [NDIG-1:0];
   logic [6:0]      displays_d [NDIG-1:0];

   logic [BW-1:0]   bcd_adj_c;
   logic [6:0]      seg_c [NDIG-1:0];
   logic [NDIG-1:0] blank_c;
   logic            ovf_c;

   // One decoder per digit, fed straight from the BCD register
   for (genvar g = 0; g < int'(NDIG); g++) begin : g_dec
      bcd_to_7seg u_dec (
         .bcd (bcd_q[4*g +: 4]),
         .seg (seg_c[g])
      );
   end

   // Out-of-range detection on the value being captured
   always_comb begin
      ovf_c = (64'(digits) > MAX_VAL);
   end

   // Add-3 correction on every nibble of 5 or more before the shift
   always_comb begin
      bcd_adj_c = bcd_q;
      for (int i = 0; i < int'(NDIG); i++) begin
         if (bcd_q[4*i +: 4] >= 4'd5) begin
            bcd_adj_c[4*i +: 4] = bcd_q[4*i +: 4] + 4'd3;
         end
      end
   end

`ifdef CALC_DISP_LZ_BLANK_EN
   // Blank every digit above the most-significant nonzero one; digit 0 always shown
   always_comb begin
      logic zero_run;
      zero_run = 1'b1;
      blank_c  = '0;
      for (int i = int'(NDIG) - 1; i >= 1; i--) begin
         zero_run   = zero_run & (bcd_q[4*i +: 4] == 4'd0);
         blank_c[i] = zero_run;
      end
   end
`else
   // All digits shown, leading zeros included
   always_comb begin
      blank_c = '0;
   end
`endif

   // FSM next-state and datapath updates
   always_comb begin
      state_d    = state_q;
      snap_d     = snap_q;
      bin_d      = bin_q;
      bcd_d      = bcd_q;
      cnt_d      = cnt_q;
      ovf_d      = ovf_q;
      force_d    = force_q;
      valid_d    = 1'b0;
      displays_d = displays_q;

      case (state_q)
         ST_IDLE: begin
            if ((digits != snap_q) || force_q) begin
               snap_d  = digits;
               bin_d   = digits;
               bcd_d   = '0;
               cnt_d   = '0;
               force_d = 1'b0;
               ovf_d   = ovf_c;
               state_d = ST_SHIFT;
            end
         end
         ST_SHIFT: begin
            {bcd_d, bin_d} = {bcd_adj_c, bin_q} << 1;
            cnt_d          = cnt_q + CW'(1);
            if (cnt_q == CW'(W - 1)) begin
               state_d = ST_DONE;
            end
         end
         ST_DONE: begin
            for (int i = 0; i < int'(NDIG); i++) begin
               if (ovf_q) begin
                  displays_d[i] = SEG_DASH;
               end else if (blank_c[i]) begin
                  displays_d[i] = SEG_BLANK;
               end else begin
                  displays_d[i] = seg_c[i];
               end
            end
            valid_d = 1'b1;
            state_d = ST_IDLE;
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State and output registers; reset forces a redisplay
   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         state_q <= ST_IDLE;
         snap_q  <= '0;
         bin_q   <= '0;
         bcd_q   <= '0;
         cnt_q   <= '0;
         ovf_q   <= 1'b0;
         force_q <= 1'b1;
         busy_q  <= 1'b0;
         valid_q <= 1'b0;
         for (int i = 0; i < int'(NDIG); i++) begin
            displays_q[i] <= SEG_BLANK;
         end
      end else begin
         state_q    <= state_d;
         snap_q     <= snap_d;
         bin_q      <= bin_d;
         bcd_q      <= bcd_d;
         cnt_q      <= cnt_d;
         ovf_q      <= ovf_d;
         force_q    <= force_d;
         busy_q     <= busy_d;
         valid_q    <= valid_d;
         displays_q <= displays_d;
      end
   end

   assign displays = displays_q;
   assign busy     = busy_q;
   assign valid    = valid_q;

endmodule

// File: tb/tb_calc_display_driver.sv
// Directed self-checking bench for calc_display_driver (default NDIG=8, W=27).
module tb_calc_display_driver;

   localparam int unsigned NDIG = 8;
   localparam int unsigned W    = 27;

   logic         clock;
   logic         reset;
   logic [W-1:0] digits;
   logic [6:0]   displays [NDIG-1:0];
   logic         busy;
   logic         valid;

   int vectors;
   int miscompares;

   calc_display_driver #(.NDIG(NDIG), .W(W)) dut (
      .clock    (clock),
      .reset    (reset),
      .digits   (digits),
      .displays (displays),
      .busy     (busy),
      .valid    (valid)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   function automatic logic [6:0] seg_of(input int unsigned d);
      case (d)
         0: return 7'b1000000;
         1: return 7'b1111001;
         2: return 7'b0100100;
         3: return 7'b0110000;
         4: return 7'b0011001;
         5: return 7'b0010010;
         6: return 7'b0000010;
         7: return 7'b1111000;
         8: return 7'b0000000;
         9: return 7'b0010000;
         default: return 7'b1111111;
      endcase
   endfunction

   // Expected pattern for display i when value v has been converted
   function automatic logic [6:0] exp_disp(input int unsigned v, input int unsigned i);
      longint unsigned p;
      p = 1;
      for (int unsigned j = 0; j < i; j++) p = p * 10;
      if (v > 99_999_999) return 7'b0111111;
`ifdef CALC_DISP_LZ_BLANK_EN
      if (i > 0 && longint'(v) < p) return 7'b1111111;
`endif
      return seg_of(int'((longint'(v) / p) % 10));
   endfunction

   task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      vectors++;
      assert (obs === exp) else begin
         miscompares++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_disp(input string tag, input int unsigned v);
      for (int unsigned i = 0; i < NDIG; i++) begin
         check($sformatf("%s_disp%0d", tag, i), 64'(displays[i]), 64'(exp_disp(v, i)));
      end
   endtask

   task automatic check_blank(input string tag);
      for (int unsigned i = 0; i < NDIG; i++) begin
         check($sformatf("%s_disp%0d", tag, i), 64'(displays[i]), 64'h7f);
      end
   endtask

   // Edges until valid is seen (sampled 1ns after each edge); -1 on timeout
   task automatic wait_valid(output int n);
      n = -1;
      for (int e = 1; e <= 100; e++) begin
         @(posedge clock); #1;
         if (valid) begin
            n = e;
            break;
         end
      end
   endtask

   // Start a conversion at the next edge and check busy rises there
   task automatic start_and_check(input string tag, input int unsigned v);
      int n;
      digits = W'(v);
      @(posedge clock); #1;
      check({tag, "_busy_rise"}, 64'(busy), 64'd1);
      check({tag, "_no_valid"}, 64'(valid), 64'd0);
      wait_valid(n);
      check({tag, "_latency"}, 64'(n), 64'd28);
      check({tag, "_busy_low"}, 64'(busy), 64'd0);
      check_disp(tag, v);
   endtask

   initial begin
      int n;
      int busy_seen;
      int valid_seen;
      vectors     = 0;
      miscompares = 0;
      reset  = 1'b1;
      digits = '0;

      // Reset state
      repeat (2) @(negedge clock);
      check("rst_busy", 64'(busy), 64'd0);
      check("rst_valid", 64'(valid), 64'd0);
      check_blank("rst");

      // Release: force triggers conversion of 0 on the first edge
      @(posedge clock); #1;
      reset = 1'b0;
      @(posedge clock); #1;
      check("first_busy", 64'(busy), 64'd1);
      wait_valid(n);
      check("first_latency", 64'(n), 64'd28);
      check_disp("zero", 0);
      @(posedge clock); #1;
      check("valid_one_cycle", 64'(valid), 64'd0);

      start_and_check("one", 1);
      start_and_check("max8", 99_999_999);
      start_and_check("ovf", 100_000_000);
      start_and_check("ovfmax", 134_217_727);
      start_and_check("mixed", 10_203_040);

      // 12, then 345 four cycles into SHIFT
      digits = W'(12);
      @(posedge clock); #1;
      check("b2b_busy", 64'(busy), 64'd1);
      repeat (4) @(posedge clock);
      #1 digits = W'(345);
      wait_valid(n);
      check("b2b_first_latency", 64'(n), 64'd24);
      check_disp("b2b_first", 12);
      @(posedge clock); #1;
      check("b2b_restart_busy", 64'(busy), 64'd1);
      check("b2b_restart_valid", 64'(valid), 64'd0);
      wait_valid(n);
      check("b2b_second_latency", 64'(n), 64'd28);
      check_disp("b2b_second", 345);

      // Reset mid-SHIFT aborts immediately
      digits = W'(777);
      @(posedge clock); #1;
      check("abort_busy", 64'(busy), 64'd1);
      repeat (10) @(posedge clock);
      #2 reset = 1'b1;
      #1;
      check("abort_busy_low", 64'(busy), 64'd0);
      check("abort_valid_low", 64'(valid), 64'd0);
      check_blank("abort");
      @(posedge clock); #1;
      check("abort_hold_valid", 64'(valid), 64'd0);
      reset = 1'b0;
      @(posedge clock); #1;
      check("redisp_busy", 64'(busy), 64'd1);
      wait_valid(n);
      check("redisp_latency", 64'(n), 64'd28);
      check_disp("redisp", 777);

      // Stable input: no further activity
      busy_seen  = 0;
      valid_seen = 0;
      repeat (100) begin
         @(posedge clock); #1;
         if (busy)  busy_seen++;
         if (valid) valid_seen++;
      end
      check("stable_busy", 64'(busy_seen), 64'd0);
      check("stable_valid", 64'(valid_seen), 64'd0);
      check_disp("stable_hold", 777);

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
